imem_dmem_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the fetch stage (IF port) and the memory stage (DM port) of the 5-stage pipeline.
- Arbitrates requests with fixed DM priority plus IF anti-starvation, sequences fixed-latency memory accesses, and returns read data.
- Generates stall_f / stall_m for the hazard logic, which freezes the upstream stages while a requester waits.

---
 rtl/imem_dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one fixed-latency unified memory between fetch (IF) and memory-stage (DM) ports.
// Optional wait-cycle counters are enabled with `define ARB_PERF_CNT_EN.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       dm_wait_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              owner_dm;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              if_win;
    logic              last_wait;

    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        if_win     = if_req & (~dm_req | (starve_cnt == SW'(STARVE_MAX)));
        case (state)
            S_IDLE: begin
                // Grants are suppressed while reset is held so outputs stay 0.
                if (rst && (if_req || dm_req)) begin
                    if_gnt     = if_win;
                    dm_gnt     = ~if_win;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == CNT_W'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            owner_dm   <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else begin
            state <= state_next;
            if (if_gnt || dm_gnt) begin
                owner_dm  <= dm_gnt;
                req_we    <= dm_gnt & dm_we;
                req_addr  <= dm_gnt ? dm_addr : if_addr;
                req_wdata <= dm_gnt ? dm_wdata : '0;
                if (if_gnt)
                    starve_cnt <= '0;
                else if (if_req && starve_cnt != SW'(STARVE_MAX))
                    starve_cnt <= starve_cnt + SW'(1);
            end
            if (state == S_ISSUE)
                wait_cnt <= CNT_W'(MEM_LAT);
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    assign last_wait = (state == S_WAIT) && (wait_cnt == CNT_W'(1));
    assign if_rvalid = last_wait & ~owner_dm;
    assign dm_rvalid = last_wait & owner_dm;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !req_we) ? mem_rdata : '0;

    assign mem_en    = (state == S_ISSUE);
    assign mem_we    = mem_en & req_we;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    assign stall_f   = rst & if_req & ~if_rvalid;
    assign stall_m   = rst & dm_req & ~dm_rvalid;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_wait_cnt <= '0;
            dm_wait_cnt <= '0;
        end else begin
            if (stall_f && if_wait_cnt != '1) if_wait_cnt <= if_wait_cnt + 32'd1;
            if (stall_m && dm_wait_cnt != '1) dm_wait_cnt <= dm_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_imem_dmem_arbiter;
    localparam int ADDR_W = 32, DATA_W = 32, MEM_LAT = 2, STARVE_MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
    logic mem_en, mem_we, stall_f, stall_m;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_wait_cnt, dm_wait_cnt;
`endif

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m)
`ifdef ARB_PERF_CNT_EN
        , .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt)
`endif
    );

    int cyc = 0;
    int n_checks = 0, n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_val(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory environment: captures accesses at mem_en and returns read data MEM_LAT cycles later.
    int rd_due = -1;
    logic [31:0] rd_data = '0;
    initial forever begin
        @(negedge clk);
        if (!rst) rd_due = -1;
        else if (mem_en) begin
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            else begin
                rd_data = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
                rd_due  = cyc + MEM_LAT;
            end
        end
    end
    initial begin
        mem_rdata = '0;
        forever begin
            tick();
            mem_rdata = (cyc == rd_due) ? rd_data : $urandom;
        end
    end

    // Reference model / predictor: transaction-level arbitration from the rules.
    typedef struct { int due; logic [31:0] data; } exp_t;
    exp_t if_q[$], dm_q[$];
    int free_at = 0, starve = 0, iss_cyc = -1, if_due = -1, dm_due = -1;
    logic iss_we;
    logic [31:0] iss_addr, iss_wdata, if_wc = '0, dm_wc = '0;

    initial begin
        bit eg_if, eg_dm, exp_sf, exp_sm, exp_en;
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_if_gnt", {31'b0, if_gnt}, 0);
                check("rst_dm_gnt", {31'b0, dm_gnt}, 0);
                check("rst_mem_en", {31'b0, mem_en}, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_stalls", {30'b0, stall_f, stall_m}, 0);
                free_at = 0; starve = 0; iss_cyc = -1; if_due = -1; dm_due = -1;
                if_q.delete(); dm_q.delete();
                if_wc = '0; dm_wc = '0;
`ifdef ARB_PERF_CNT_EN
                check("rst_perf", if_wait_cnt | dm_wait_cnt, 0);
`endif
            end else begin
                eg_if = 0; eg_dm = 0;
                if (cyc >= free_at && (if_req || dm_req)) begin
                    if (if_req && (!dm_req || starve == STARVE_MAX)) eg_if = 1;
                    else eg_dm = 1;
                    free_at = cyc + 2 + MEM_LAT;
                    iss_cyc = cyc + 1;
                    x.due   = cyc + 1 + MEM_LAT;
                    if (eg_if) begin
                        starve = 0;
                        iss_we = 0; iss_addr = if_addr; iss_wdata = '0;
                        x.data = ref_read(if_addr);
                        if_due = x.due;
                        if_q.push_back(x);
                    end else begin
                        if (if_req && starve < STARVE_MAX) starve++;
                        iss_we = dm_we; iss_addr = dm_addr; iss_wdata = dm_wdata;
                        if (dm_we) begin
                            ref_mem[dm_addr] = dm_wdata;
                            x.data = '0;
                        end else x.data = ref_read(dm_addr);
                        dm_due = x.due;
                        dm_q.push_back(x);
                    end
                end
                check("if_gnt", {31'b0, if_gnt}, {31'b0, eg_if});
                check("dm_gnt", {31'b0, dm_gnt}, {31'b0, eg_dm});
                exp_en = (cyc == iss_cyc);
                check("mem_en", {31'b0, mem_en}, {31'b0, exp_en});
                if (exp_en) begin
                    check("mem_we", {31'b0, mem_we}, {31'b0, iss_we});
                    check("mem_addr", mem_addr, iss_addr);
                    if (iss_we) check("mem_wdata", mem_wdata, iss_wdata);
                end
                exp_sf = if_req && (cyc != if_due);
                exp_sm = dm_req && (cyc != dm_due);
                check("stall_f", {31'b0, stall_f}, {31'b0, exp_sf});
                check("stall_m", {31'b0, stall_m}, {31'b0, exp_sm});
`ifdef ARB_PERF_CNT_EN
                check("if_wait_cnt", if_wait_cnt, if_wc);
                check("dm_wait_cnt", dm_wait_cnt, dm_wc);
`endif
                if (exp_sf && if_wc != '1) if_wc++;
                if (exp_sm && dm_wc != '1) dm_wc++;
            end
        end
    end

    // Monitor: pops the expected response when it falls due and compares the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (if_q.size() > 0 && if_q[0].due == cyc) begin
                    e = if_q.pop_front();
                    check("if_rvalid", {31'b0, if_rvalid}, 1);
                    check("if_rdata", if_rdata, e.data);
                end else begin
                    check("if_rvalid_idle", {31'b0, if_rvalid}, 0);
                    check("if_rdata_idle", if_rdata, 0);
                end
                if (dm_q.size() > 0 && dm_q[0].due == cyc) begin
                    e = dm_q.pop_front();
                    check("dm_rvalid", {31'b0, dm_rvalid}, 1);
                    check("dm_rdata", dm_rdata, e.data);
                end else begin
                    check("dm_rvalid_idle", {31'b0, dm_rvalid}, 0);
                    check("dm_rdata_idle", dm_rdata, 0);
                end
            end
        end
    end

    // Stimulus-side observation of handshakes (used for request sequencing and event logs).
    bit if_g_s, dm_g_s, if_rv_s, dm_rv_s;
    int if_gnt_cyc = -1, dm_gnt_cyc = -1, if_rv_cyc = -1, dm_rv_cyc = -1;
    int log_cyc[$];
    bit log_dm[$];
    initial forever begin
        @(negedge clk);
        if_g_s = if_gnt; dm_g_s = dm_gnt; if_rv_s = if_rvalid; dm_rv_s = dm_rvalid;
        if (if_gnt) begin if_gnt_cyc = cyc; log_cyc.push_back(cyc); log_dm.push_back(0); end
        if (dm_gnt) begin dm_gnt_cyc = cyc; log_cyc.push_back(cyc); log_dm.push_back(1); end
        if (if_rvalid) if_rv_cyc = cyc;
        if (dm_rvalid) dm_rv_cyc = cyc;
    end

    task automatic run_until_idle(int max);
        for (int i = 0; i < max; i++) begin
            tick();
            if (if_rv_s) if_req = 0;
            if (dm_rv_s) dm_req = 0;
            if (!if_req && !dm_req) return;
        end
        check("drain_timeout", {30'b0, if_req, dm_req}, 0);
        if_req = 0; dm_req = 0;
    endtask

    task automatic pulse_reset();
        rst = 0;
        repeat (2) tick();
        rst = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int t0;
    bit if_gd, dm_gd;
    int s_cyc [4] = '{0, 4, 8, 12};
    bit s_dm  [4] = '{1, 1, 0, 1};

    initial begin
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        env_mem[32'h10] = 32'h00500093;
        ref_mem[32'h10] = 32'h00500093;
        repeat (3) tick();
        rst = 1;

        // IF alone
        t0 = cyc; if_addr = 32'h10; if_req = 1;
        run_until_idle(20);
        check("ifalone_gnt_cycle", if_gnt_cyc - t0, 0);
        check("ifalone_rv_cycle", if_rv_cyc - t0, 3);

        // DM store
        t0 = cyc; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_req = 1;
        run_until_idle(20);
        check("store_rv_cycle", dm_rv_cyc - t0, 3);

        // Simultaneous first request, from a fresh reset
        pulse_reset();
        t0 = cyc; dm_we = 0; if_req = 1; dm_req = 1;
        run_until_idle(30);
        check("sim_dm_gnt", dm_gnt_cyc - t0, 0);
        check("sim_dm_rv", dm_rv_cyc - t0, 3);
        check("sim_if_gnt", if_gnt_cyc - t0, 4);
        check("sim_if_rv", if_rv_cyc - t0, 7);
`ifdef ARB_PERF_CNT_EN
        check("sim_if_wait_cnt", if_wait_cnt, 7);
        check("sim_dm_wait_cnt", dm_wait_cnt, 3);
`endif

        // Starvation: both held continuously
        log_cyc.delete(); log_dm.delete();
        t0 = cyc; if_req = 1; dm_req = 1;
        repeat (14) tick();
        run_until_idle(40);
        check("starve_grant_count", log_cyc.size(), 5);
        for (int i = 0; i < 4; i++)
            if (i < log_cyc.size()) begin
                check("starve_grant_cycle", log_cyc[i] - t0, s_cyc[i]);
                check("starve_grant_port", {31'b0, log_dm[i]}, {31'b0, s_dm[i]});
            end

        // Reset during WAIT of an IF transaction
        t0 = cyc; if_req = 1; if_addr = 32'h14;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        check("midrst_outputs", {29'b0, mem_en, if_rvalid, if_gnt}, 0);
        repeat (2) tick();
        rst = 1;
        @(negedge clk);
        check("midrst_fresh_gnt", {31'b0, if_gnt}, 1);
        run_until_idle(20);

        // Randomized traffic with early drops and back-to-back holds
        if_gd = 0; dm_gd = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (if_g_s) if_gd = 1;
            if (if_rv_s) if_gd = 0;
            if (if_req) begin
                if (if_rv_s) begin
                    if ($urandom_range(1, 0) == 1) if_addr = 32'($urandom_range(7, 0)) << 2;
                    else if_req = 0;
                end else if ($urandom_range(15, 0) == 0) if_req = 0;
            end else if (!if_gd && $urandom_range(2, 0) == 0) begin
                if_addr = 32'($urandom_range(7, 0)) << 2; if_req = 1;
            end
            if (dm_g_s) dm_gd = 1;
            if (dm_rv_s) dm_gd = 0;
            if (dm_req) begin
                if (dm_rv_s) begin
                    if ($urandom_range(1, 0) == 1) begin
                        dm_addr = 32'($urandom_range(7, 0)) << 2; dm_we = 1'($urandom_range(1, 0)); dm_wdata = $urandom;
                    end else dm_req = 0;
                end else if ($urandom_range(15, 0) == 0) dm_req = 0;
            end else if (!dm_gd && $urandom_range(2, 0) == 0) begin
                dm_addr = 32'($urandom_range(7, 0)) << 2; dm_we = 1'($urandom_range(1, 0)); dm_wdata = $urandom;
                dm_req = 1;
            end
        end
        if_req = 0; dm_req = 0;
        repeat (MEM_LAT + 4) tick();
        check("if_queue_empty", if_q.size(), 0);
        check("dm_queue_empty", dm_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
